sync_fifo_6: RTL and testbench
==============================

# sync_fifo_6

Synchronous first-word-fall-through FIFO, 6 entries deep by default, with valid/ready handshakes on both sides. It buffers data between a producer and a consumer in one clock domain. It exports its live occupancy as `number_of_current_entries`, which drives the FIFO coverage checker that sits directly downstream. It also tracks a peak-occupancy high-water mark for debug.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each entry.
- `DEPTH`, 6, number of entries; legal range 2..7, so that the count fits in 3 bits.
- `AF_LEVEL`, 5, `almost_full` threshold; legal range 1..`DEPTH`.

Ports:
- `clk` input 1: single clock; all logic updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: producer has data on `in_data`.
- `in_ready` output 1: FIFO can accept; equals `!full`.
- `in_data` input `DATA_WIDTH`: write data.
- `out_valid` output 1: head entry present; equals `!empty`.
- `out_ready` input 1: consumer accepts the head.
- `out_data` output `DATA_WIDTH`: head entry; all zeros while empty.
- `number_of_current_entries` output 3: registered occupancy, 0..`DEPTH`.
- `full` output 1: count == `DEPTH`.
- `empty` output 1: count == 0.
- `almost_full` output 1: count >= `AF_LEVEL`.
- `max_entries` output 3: highest count reached since reset.

## Operation
- Push: `push = in_valid && in_ready`. On a push, write `in_data` to `mem[wr_ptr]` and advance `wr_ptr`.
- Pop: `pop = out_valid && out_ready`. On a pop, advance `rd_ptr`.
- Pointers are 3 bits, range 0..`DEPTH-1`. They wrap explicitly: when the pointer equals `DEPTH-1`, the next value is 0. No power-of-two wrap is allowed, because `DEPTH`=6.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together, or neither: unchanged
- Full/empty come only from the count register. There is no pointer-compare ambiguity.
- Full with `in_valid`=1: `in_ready`=0, no write, no state change. Simultaneous `out_ready` still pops. The next cycle has count `DEPTH-1` and `in_ready`=1.
- Empty: `out_valid`=0 and `out_data`=0. A pop cannot occur. A push while empty has no same-cycle bypass.
- FWFT: `out_data` = `mem[rd_ptr]`, a combinational read, masked to zero when empty.
- `full`, `empty`, `almost_full`, `in_ready` and `out_valid` are decoded combinationally from the count register only. They never depend on same-cycle `in_valid` or `out_ready`.
- High-water mark: each cycle, `max_entries <= max(max_entries, next_count)`. It is cleared only by reset.
- Storage array is not reset. Pointers, count and `max_entries` are reset.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - pointers = 0, count = 0, `max_entries` = 0
  - outputs: `empty`=1, `full`=0, `almost_full`=0, `in_ready`=1, `out_valid`=0, `out_data`=0
  - Reset overrides any push or pop in the same cycle.
- Reset mid-operation discards all contents. The cycle after reset deassertion behaves as an empty FIFO.
- Write-to-read latency is 1 cycle. Data pushed at edge N is visible on `out_data` with `out_valid`=1 after edge N; it can be popped at edge N+1.
- Sustained throughput is 1 push and 1 pop per cycle at any count from 1 to `DEPTH-1`.
- At count `DEPTH` or 0, only one direction is legal; the other side stalls.
- `number_of_current_entries` and `max_entries` are registered and change only at rising edges.
- Handshake rules:
  - Producer: may hold or drop `in_valid` freely.
  - FIFO: never deasserts `out_valid` without a pop, except on reset.
  - FIFO: holds `out_data` stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset check:
  - Stimulus: hold `rst_n`=0 for 3 cycles with `in_valid`=1.
  - Required: count=0, `empty`=1, `in_ready`=1, `out_valid`=0, `out_data`=0, `max_entries`=0.
- Fill to full:
  - Stimulus: push 0x11..0x66 on 6 consecutive cycles with `out_ready`=0.
  - Required: count steps 1..6; `almost_full`=1 from count 5; `full`=1 and `in_ready`=0 at 6; a 7th push of 0x77 is ignored; `max_entries`=6.
- Drain and wrap:
  - Stimulus: from full, pop 6; then push 0xA0..0xA3 and pop 4.
  - Required:
    - pops return 0x11..0x66 in order, then 0xA0..0xA3 across the pointer wrap from 5 to 0;
    - `empty`=1 at the end;
    - `max_entries` stays 6.
- Simultaneous push and pop:
  - Stimulus: at count 3, assert push and pop for 10 cycles.
  - Required: count stays 3 throughout; outputs remain in push order.
- Boundary simultaneity:
  - Stimulus 1: at full, assert `in_valid` and `out_ready` together. Required: pop only, count becomes 5.
  - Stimulus 2: at empty, assert both. Required: push only, count becomes 1, data appears the next cycle.
- Reset mid-stream:
  - Stimulus: at count 4, drive `rst_n`=0 for 1 cycle.
  - Required: count=0 and `empty`=1; the next push 0x5A is popped as 0x5A.

Source files
------------

// File: rtl/sync_fifo_6.sv
// sync_fifo_6: first-word-fall-through FIFO with count-based full/empty and a peak-occupancy mark
module sync_fifo_6 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 6,
  parameter int AF_LEVEL   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            number_of_current_entries,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [2:0]            max_entries
);
  localparam logic [2:0] LAST    = 3'(DEPTH - 1);
  localparam logic [2:0] FULL_CT = 3'(DEPTH);
  localparam logic [2:0] AF_CT   = 3'(AF_LEVEL);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d, max_q, max_d;
  logic push, pop;
  // Status flags decode from the count register only, never from same-cycle handshakes
  assign full        = count_q == FULL_CT;
  assign empty       = count_q == 3'd0;
  assign almost_full = count_q >= AF_CT;
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign number_of_current_entries = count_q;
  assign max_entries = max_q;
  // Explicit wrap because DEPTH need not be a power of two
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q == LAST ? 3'd0 : wr_ptr_q + 3'd1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == LAST ? 3'd0 : rd_ptr_q + 3'd1) : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 3'd1 : (pop && !push) ? count_q - 3'd1 : count_q;
    max_d    = count_d > max_q ? count_d : max_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 3'd0;
      max_q    <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_sync_fifo_6.sv
// tb_sync_fifo_6: table-driven directed vectors plus hand-written boundary and reset sequences
module tb_sync_fifo_6;
  logic clk = 1'b0, rst_n, in_valid, in_ready, out_valid, out_ready, full, empty, almost_full;
  logic [7:0] in_data, out_data;
  logic [2:0] cnt, max_e;
  int n_tests = 0, n_fail = 0;

  typedef struct packed {
    logic       r, iv;
    logic [7:0] id;
    logic       ordy;
    logic [2:0] cnt;
    logic       ov;
    logic [7:0] od;
    logic       full, af, ir;
    logic [2:0] mx;
  } vec_t;
  vec_t vecs[$];

  sync_fifo_6 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .number_of_current_entries(cnt), .full(full), .empty(empty),
    .almost_full(almost_full), .max_entries(max_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    rst_n = r; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] drain_exp [5];
    drain_exp = '{8'hC8, 8'hC9, 8'hD0, 8'hD1, 8'hD2};
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    //  r  iv  id     ordy cnt  ov  od    full af  ir  mx
    for (int i = 0; i < 3; i++) add('{1'b0,1'b1,8'hFF,1'b0,3'd0,1'b0,8'h00,1'b0,1'b0,1'b1,3'd0});
    add('{1'b1,1'b1,8'h11,1'b0,3'd1,1'b1,8'h11,1'b0,1'b0,1'b1,3'd1});
    add('{1'b1,1'b1,8'h22,1'b0,3'd2,1'b1,8'h11,1'b0,1'b0,1'b1,3'd2});
    add('{1'b1,1'b1,8'h33,1'b0,3'd3,1'b1,8'h11,1'b0,1'b0,1'b1,3'd3});
    add('{1'b1,1'b1,8'h44,1'b0,3'd4,1'b1,8'h11,1'b0,1'b0,1'b1,3'd4});
    add('{1'b1,1'b1,8'h55,1'b0,3'd5,1'b1,8'h11,1'b0,1'b1,1'b1,3'd5});
    add('{1'b1,1'b1,8'h66,1'b0,3'd6,1'b1,8'h11,1'b1,1'b1,1'b0,3'd6});
    add('{1'b1,1'b1,8'h77,1'b0,3'd6,1'b1,8'h11,1'b1,1'b1,1'b0,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd5,1'b1,8'h22,1'b0,1'b1,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd4,1'b1,8'h33,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd3,1'b1,8'h44,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd2,1'b1,8'h55,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd1,1'b1,8'h66,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd0,1'b0,8'h00,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b1,8'hA0,1'b0,3'd1,1'b1,8'hA0,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b1,8'hA1,1'b0,3'd2,1'b1,8'hA0,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b1,8'hA2,1'b0,3'd3,1'b1,8'hA0,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b1,8'hA3,1'b0,3'd4,1'b1,8'hA0,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd3,1'b1,8'hA1,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd2,1'b1,8'hA2,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd1,1'b1,8'hA3,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b0,8'h00,1'b1,3'd0,1'b0,8'h00,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b1,8'hB0,1'b0,3'd1,1'b1,8'hB0,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b1,8'hB1,1'b0,3'd2,1'b1,8'hB0,1'b0,1'b0,1'b1,3'd6});
    add('{1'b1,1'b1,8'hB2,1'b0,3'd3,1'b1,8'hB0,1'b0,1'b0,1'b1,3'd6});
    // stream B0,B1,B2,C0..C9 through at constant count 3: head after k-th pop is element k+1
    for (int k = 0; k < 10; k++)
      add('{1'b1,1'b1,8'(8'hC0 + k),1'b1,3'd3,1'b1,
            (k == 0) ? 8'hB1 : (k == 1) ? 8'hB2 : 8'(8'hC0 + k - 2),
            1'b0,1'b0,1'b1,3'd6});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d count", i), 32'(cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(!vecs[i].ov));
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].full));
      chk($sformatf("vec%0d almost_full", i), 32'(almost_full), 32'(vecs[i].af));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      chk($sformatf("vec%0d max_entries", i), 32'(max_e), 32'(vecs[i].mx));
    end

    // full boundary: contents C7,C8,C9 -> add D0..D2, then push+pop at full pops only
    step(1'b1, 1'b1, 8'hD0, 1'b0);
    step(1'b1, 1'b1, 8'hD1, 1'b0);
    step(1'b1, 1'b1, 8'hD2, 1'b0);
    chk("full count", 32'(cnt), 32'd6);
    chk("full flag", 32'(full), 32'd1);
    chk("full in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("full pop-only count", 32'(cnt), 32'd5);
    chk("full pop-only head", 32'(out_data), 32'h00C8);
    chk("full pop-only in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain%0d data", i), 32'(out_data), 32'(drain_exp[i]));
      step(1'b1, 1'b0, 8'h00, 1'b1);
    end
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain max", 32'(max_e), 32'd6);

    // empty boundary: push+pop while empty pushes only, no bypass
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h5F; out_ready = 1'b1;
    #1;
    chk("empty no bypass out_valid", 32'(out_valid), 32'd0);
    chk("empty no bypass out_data", 32'(out_data), 32'd0);
    step(1'b1, 1'b1, 8'h5F, 1'b1);
    chk("empty push-only count", 32'(cnt), 32'd1);
    chk("empty push-only data", 32'(out_data), 32'h005F);
    chk("empty push-only valid", 32'(out_valid), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("empty pop back count", 32'(cnt), 32'd0);

    // reset mid-stream at count 4
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'hE0 + i), 1'b0);
    chk("pre-reset count", 32'(cnt), 32'd4);
    step(1'b0, 1'b1, 8'h99, 1'b1);
    chk("mid reset count", 32'(cnt), 32'd0);
    chk("mid reset empty", 32'(empty), 32'd1);
    chk("mid reset out_data", 32'(out_data), 32'd0);
    chk("mid reset max", 32'(max_e), 32'd0);
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    chk("post reset count", 32'(cnt), 32'd1);
    chk("post reset max", 32'(max_e), 32'd1);
    chk("post reset head", 32'(out_data), 32'h005A);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("post reset pop count", 32'(cnt), 32'd0);
    chk("post reset pop empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
